// File: rtl/hmmm_sys_pkg.sv
// rtl/hmmm_sys_pkg.sv - shared widths and arbiter state type for the HMMM system slice
package hmmm_sys_pkg;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        HOLD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } arb_state_t;
endpackage

// File: rtl/flopenr.sv
// rtl/flopenr.sv - two-phase register with enable and synchronous reset
module flopenr #(
    parameter int WIDTH = 8
) (
    input  logic             ph1,
    input  logic             ph2,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] m_q;

    always_ff @(posedge ph2) begin
        if (reset)   m_q <= '0;
        else if (en) m_q <= d;
    end

    always_ff @(posedge ph1) q <= m_q;
endmodule

// File: rtl/flopr.sv
// rtl/flopr.sv - two-phase register with synchronous reset: d captured in ph2, q presented in ph1
module flopr #(
    parameter int WIDTH = 8
) (
    input  logic             ph1,
    input  logic             ph2,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] m_q;

    always_ff @(posedge ph2) begin
        if (reset) m_q <= '0;
        else       m_q <= d;
    end

    always_ff @(posedge ph1) q <= m_q;
endmodule

// File: rtl/run_timer.sv
// rtl/run_timer.sv - loadable down-counter; done_o is high while the count sits at zero
module run_timer #(
    parameter int WIDTH = 16
) (
    input  logic             ph1_i,
    input  logic             ph2_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             done_o
);
    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i)                    count_d = load_val_i;
        else if (en_i && !done_o)      count_d = count_q - 1'b1;
    end

    flopr #(.WIDTH(WIDTH)) u_count (
        .ph1(ph1_i), .ph2(ph2_i), .reset(reset_i), .d(count_d), .q(count_q)
    );

    assign done_o = (count_q == '0);
endmodule

// File: rtl/sram_boot_arbiter.sv
// rtl/sram_boot_arbiter.sv - shares one SRAM between the host loader and the HMMM core, sequencing core runs
module sram_boot_arbiter
    import hmmm_sys_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = ADDR_W,
    parameter int                    DATA_WIDTH  = DATA_W,
    parameter logic [ADDR_WIDTH-1:0] MAILBOX_ADR = {ADDR_WIDTH{1'b1}},
    parameter int                    HOLD_CYCLES = 2,
    parameter int                    TIMEOUT     = 4096
) (
    input  logic                  ph1,
    input  logic                  ph2,
    input  logic                  reset,
    input  logic                  host_valid,
    output logic                  host_ready,
    input  logic                  host_write,
    input  logic [ADDR_WIDTH-1:0] host_adr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  host_rvalid,
    input  logic                  host_start,
    input  logic                  host_abort,
    output logic                  cpu_reset,
    input  logic                  cpu_memwrite,
    input  logic [ADDR_WIDTH-1:0] cpu_adr,
    input  logic [7:0]            cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic [ADDR_WIDTH-1:0] sram_adr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata,
    output logic [1:0]            state_o,
    output logic                  result_valid,
    output logic                  result_to,
    output logic [7:0]            result_data
);
    localparam int TMR_W = 16;
    localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
    localparam logic [TMR_W-1:0] RUN_LOAD  = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_t       state_q, state_d;
    logic [1:0]       state_raw_q;
    logic             host_side, host_acc, host_rd;
    logic             mailbox_hit, timeout_hit, enter_hold;
    logic             tmr_load, tmr_done;
    logic [TMR_W-1:0] tmr_val;
    logic [9:0]       res_q, res_d;
    logic [15:0]      run_cnt_q, run_cnt_d;

    assign state_q     = arb_state_t'(state_raw_q);
    assign host_side   = (state_q == LOAD) || (state_q == DONE);
    assign host_acc    = host_side && host_valid && !reset;
    assign host_rd     = host_acc && !host_write;
    assign mailbox_hit = (state_q == RUN) && cpu_memwrite && (cpu_adr == MAILBOX_ADR);
    assign timeout_hit = (state_q == RUN) && (TIMEOUT != 0) && tmr_done;

    // Abort outranks everything; a start in LOAD/DONE arms the HOLD countdown.
    always_comb begin
        state_d    = state_q;
        enter_hold = 1'b0;
        tmr_load   = 1'b0;
        tmr_val    = HOLD_LOAD;
        case (state_q)
            LOAD, DONE: begin
                if (host_abort) state_d = LOAD;
                else if (host_start) begin
                    state_d    = HOLD;
                    enter_hold = 1'b1;
                    tmr_load   = 1'b1;
                end
            end
            HOLD: begin
                if (host_abort) state_d = LOAD;
                else if (tmr_done) begin
                    state_d  = RUN;
                    tmr_load = 1'b1;
                    tmr_val  = RUN_LOAD;
                end
            end
            RUN: begin
                if (host_abort) state_d = LOAD;
                else if (mailbox_hit || timeout_hit) state_d = DONE;
            end
            default: state_d = LOAD;
        endcase
    end

    // Results: {valid, timed_out, data}; mailbox takes precedence over timeout.
    always_comb begin
        res_d = res_q;
        if (enter_hold) res_d = '0;
        else if (!host_abort) begin
            if (mailbox_hit)      res_d = {1'b1, res_q[8], cpu_wdata};
            else if (timeout_hit) res_d[8] = 1'b1;
        end
    end

    always_comb begin
        run_cnt_d = run_cnt_q;
        if (enter_hold)                                run_cnt_d = '0;
        else if (state_q == RUN && run_cnt_q != '1)    run_cnt_d = run_cnt_q + 1'b1;
    end

    always_comb begin
        sram_ce_n  = 1'b0;
        sram_we_n  = 1'b1;
        sram_oe_n  = 1'b0;
        sram_adr   = host_adr;
        sram_wdata = host_wdata;
        if (!host_side) begin
            sram_adr   = cpu_adr;
            sram_wdata = DATA_WIDTH'(cpu_wdata);
            sram_we_n  = !cpu_memwrite;
            sram_oe_n  = cpu_memwrite;
        end else if (host_acc && host_write) begin
            sram_we_n = 1'b0;
            sram_oe_n = 1'b1;
        end
    end

    flopr   #(.WIDTH(2))          u_state   (.ph1, .ph2, .reset, .d(state_d),   .q(state_raw_q));
    flopr   #(.WIDTH(10))         u_result  (.ph1, .ph2, .reset, .d(res_d),     .q(res_q));
    flopr   #(.WIDTH(16))         u_run_cnt (.ph1, .ph2, .reset, .d(run_cnt_d), .q(run_cnt_q));
    flopr   #(.WIDTH(1))          u_rvalid  (.ph1, .ph2, .reset, .d(host_rd),   .q(host_rvalid));
    flopenr #(.WIDTH(DATA_WIDTH)) u_rdata   (.ph1, .ph2, .reset, .en(host_rd), .d(sram_rdata), .q(host_rdata));

    run_timer #(.WIDTH(TMR_W)) u_timer (
        .ph1_i(ph1), .ph2_i(ph2), .reset_i(reset), .load_i(tmr_load), .load_val_i(tmr_val),
        .en_i((state_q == HOLD) || (state_q == RUN)), .done_o(tmr_done)
    );

    assign host_ready   = host_acc;
    assign cpu_reset    = (state_q != RUN);
    assign cpu_rdata    = sram_rdata;
    assign state_o      = state_q;
    assign result_valid = res_q[9];
    assign result_to    = res_q[8];
    assign result_data  = res_q[7:0];
endmodule

// File: tb/tb_sram_boot_arbiter.sv
// tb/tb_sram_boot_arbiter.sv - vector table, corner sequences and randomized run against a reference model
module tb_sram_boot_arbiter;
    localparam int HOLD_N = 2;
    localparam int TO_N   = 16;
    localparam int S_LOAD = 0, S_HOLD = 1, S_RUN = 2, S_DONE = 3;

    logic        ph1, ph2, reset;
    logic        host_valid, host_ready, host_write, host_rvalid, host_start, host_abort;
    logic [7:0]  host_adr, cpu_adr, cpu_wdata, sram_adr, result_data;
    logic [15:0] host_wdata, host_rdata, cpu_rdata, sram_wdata, sram_rdata;
    logic        cpu_reset, cpu_memwrite, sram_ce_n, sram_oe_n, sram_we_n;
    logic        result_valid, result_to;
    logic [1:0]  state_o;

    sram_boot_arbiter #(.HOLD_CYCLES(HOLD_N), .TIMEOUT(TO_N)) dut (
        .ph1(ph1), .ph2(ph2), .reset(reset),
        .host_valid(host_valid), .host_ready(host_ready), .host_write(host_write),
        .host_adr(host_adr), .host_wdata(host_wdata), .host_rdata(host_rdata),
        .host_rvalid(host_rvalid), .host_start(host_start), .host_abort(host_abort),
        .cpu_reset(cpu_reset), .cpu_memwrite(cpu_memwrite), .cpu_adr(cpu_adr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_adr(sram_adr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .state_o(state_o), .result_valid(result_valid), .result_to(result_to),
        .result_data(result_data)
    );

    // Asynchronous SRAM: combinational read, write committed at the end of the cycle.
    logic [15:0] mem [256];
    assign sram_rdata = mem[sram_adr];
    always @(posedge ph2) if (!sram_ce_n && !sram_we_n) mem[sram_adr] <= sram_wdata;

    initial begin
        ph1 = 0; ph2 = 0;
        forever begin #1 ph1 = 1; #8 ph1 = 0; #1 ph2 = 1; #8 ph2 = 0; end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    int n_cmp = 0, n_bad = 0, runs;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: cycle counts rather than countdowns, plus a shadow of SRAM contents.
    int          m_state, hold_seen, run_cycles;
    logic        m_resv, m_rto, m_rvalid;
    logic [7:0]  m_resd;
    logic [15:0] m_rdata;
    logic [15:0] shadow [256];

    task automatic model_step();
        bit side, acc;
        side = (m_state == S_LOAD) || (m_state == S_DONE);
        acc  = side && host_valid && !reset;
        m_rvalid = acc && !host_write;
        if (m_rvalid) m_rdata = shadow[host_adr];
        if (acc && host_write) shadow[host_adr] = host_wdata;
        if (!side && cpu_memwrite) shadow[cpu_adr] = {8'h00, cpu_wdata};
        if (reset) begin
            m_state = S_LOAD; hold_seen = 0; run_cycles = 0;
            m_resv = 0; m_rto = 0; m_resd = 0; m_rvalid = 0; m_rdata = 0;
        end else if (side) begin
            if (host_abort) m_state = S_LOAD;
            else if (host_start) begin
                m_state = S_HOLD; hold_seen = 0; run_cycles = 0;
                m_resv = 0; m_rto = 0; m_resd = 0;
            end
        end else if (host_abort) m_state = S_LOAD;
        else if (m_state == S_HOLD) begin
            hold_seen++;
            if (hold_seen >= HOLD_N) m_state = S_RUN;
        end else begin
            run_cycles++;
            if (cpu_memwrite && cpu_adr == 8'hFF) begin
                m_state = S_DONE; m_resv = 1; m_resd = cpu_wdata;
            end else if (run_cycles == TO_N) begin
                m_state = S_DONE; m_rto = 1;
            end
        end
    endtask

    task automatic check_model();
        bit side, acc, ewe;
        logic [7:0] ea;
        side = (m_state == S_LOAD) || (m_state == S_DONE);
        acc  = side && host_valid && !reset;
        ea   = side ? host_adr : cpu_adr;
        ewe  = side ? !(acc && host_write) : !cpu_memwrite;
        chk("rnd_state", state_o, m_state);
        chk("rnd_cpu_reset", cpu_reset, m_state != S_RUN);
        chk("rnd_host_ready", host_ready, acc);
        chk("rnd_rvalid", host_rvalid, m_rvalid);
        if (m_rvalid) chk("rnd_rdata", host_rdata, m_rdata);
        chk("rnd_result", {result_valid, result_to, result_data}, {m_resv, m_rto, m_resd});
        chk("rnd_sram_adr", sram_adr, ea);
        chk("rnd_sram_we_n", sram_we_n, ewe);
        chk("rnd_sram_oe_n", sram_oe_n, !ewe);
        if (!ewe) chk("rnd_sram_wdata", sram_wdata, side ? host_wdata : {8'h00, cpu_wdata});
        chk("rnd_cpu_rdata", cpu_rdata, shadow[ea]);
    endtask

    task automatic adv();
        model_step();
        @(posedge ph1); #1;
    endtask

    task automatic idle();
        host_valid = 0; host_write = 0; host_adr = 0; host_wdata = 0; host_start = 0; host_abort = 0;
        cpu_memwrite = 0; cpu_adr = 0; cpu_wdata = 0;
    endtask

    typedef struct {
        logic v, w; logic [7:0] adr; logic [15:0] wd; logic st, ab, mw; logic [7:0] cadr, cwd;
        logic [1:0] e_st; logic e_cr, e_rdy, e_rv; logic [15:0] e_rd; logic e_resv; logic [7:0] e_resd;
    } vec_t;
    vec_t tbl [13];

    initial begin
        // Host write/read-back, then a core run ending on a mailbox store.
        tbl[0]  = '{1'b1,1'b1,8'h03,16'h002D,1'b0,1'b0,1'b0,8'h00,8'h00, 2'd0,1'b1,1'b1,1'b0,16'h0000,1'b0,8'h00};
        tbl[1]  = '{1'b1,1'b0,8'h03,16'h0000,1'b0,1'b0,1'b0,8'h00,8'h00, 2'd0,1'b1,1'b1,1'b0,16'h0000,1'b0,8'h00};
        tbl[2]  = '{1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,1'b0,8'h00,8'h00, 2'd0,1'b1,1'b0,1'b1,16'h002D,1'b0,8'h00};
        tbl[3]  = '{1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,1'b0,8'h00,8'h00, 2'd0,1'b1,1'b0,1'b0,16'h0000,1'b0,8'h00};
        tbl[4]  = '{1'b1,1'b1,8'h00,16'h1234,1'b0,1'b0,1'b0,8'h00,8'h00, 2'd0,1'b1,1'b1,1'b0,16'h0000,1'b0,8'h00};
        tbl[5]  = '{1'b0,1'b0,8'h00,16'h0000,1'b1,1'b0,1'b0,8'h00,8'h00, 2'd0,1'b1,1'b0,1'b0,16'h0000,1'b0,8'h00};
        tbl[6]  = '{1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,1'b0,8'h00,8'h00, 2'd1,1'b1,1'b0,1'b0,16'h0000,1'b0,8'h00};
        tbl[7]  = '{1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,1'b0,8'h00,8'h00, 2'd1,1'b1,1'b0,1'b0,16'h0000,1'b0,8'h00};
        tbl[8]  = '{1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,1'b0,8'h00,8'h00, 2'd2,1'b0,1'b0,1'b0,16'h0000,1'b0,8'h00};
        tbl[9]  = '{1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,1'b1,8'hFF,8'h2D, 2'd2,1'b0,1'b0,1'b0,16'h0000,1'b0,8'h00};
        tbl[10] = '{1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,1'b0,8'h00,8'h00, 2'd3,1'b1,1'b0,1'b0,16'h0000,1'b1,8'h2D};
        tbl[11] = '{1'b1,1'b0,8'hFF,16'h0000,1'b0,1'b0,1'b0,8'h00,8'h00, 2'd3,1'b1,1'b1,1'b0,16'h0000,1'b1,8'h2D};
        tbl[12] = '{1'b0,1'b0,8'h00,16'h0000,1'b0,1'b0,1'b0,8'h00,8'h00, 2'd3,1'b1,1'b0,1'b1,16'h002D,1'b1,8'h2D};

        for (int i = 0; i < 256; i++) begin mem[i] = 16'h0000; shadow[i] = 16'h0000; end
        m_state = S_LOAD; hold_seen = 0; run_cycles = 0;
        m_resv = 0; m_rto = 0; m_resd = 0; m_rvalid = 0; m_rdata = 0;
        idle(); reset = 1;
        @(posedge ph1); #1;
        #2; adv();
        host_valid = 1; host_write = 1;
        #2;
        chk("reset_state", state_o, 2'd0);
        chk("reset_cpu_reset", cpu_reset, 1'b1);
        chk("reset_host_ready", host_ready, 1'b0);
        chk("reset_rvalid", host_rvalid, 1'b0);
        chk("reset_result", {result_valid, result_to, result_data}, 10'd0);
        chk("reset_sram_ctl", {sram_ce_n, sram_we_n, sram_oe_n}, 3'b010);
        adv();
        reset = 0; idle();

        for (int i = 0; i < 13; i++) begin
            host_valid = tbl[i].v; host_write = tbl[i].w; host_adr = tbl[i].adr; host_wdata = tbl[i].wd;
            host_start = tbl[i].st; host_abort = tbl[i].ab;
            cpu_memwrite = tbl[i].mw; cpu_adr = tbl[i].cadr; cpu_wdata = tbl[i].cwd;
            #2;
            chk($sformatf("vec%0d_state", i), state_o, tbl[i].e_st);
            chk($sformatf("vec%0d_cpu_reset", i), cpu_reset, tbl[i].e_cr);
            chk($sformatf("vec%0d_host_ready", i), host_ready, tbl[i].e_rdy);
            chk($sformatf("vec%0d_rvalid", i), host_rvalid, tbl[i].e_rv);
            if (tbl[i].e_rv) chk($sformatf("vec%0d_rdata", i), host_rdata, tbl[i].e_rd);
            chk($sformatf("vec%0d_result", i), {result_valid, result_data}, {tbl[i].e_resv, tbl[i].e_resd});
            adv();
        end
        idle();

        // Timeout: exactly TO_N RUN cycles with an idle core.
        host_start = 1; #2; adv(); host_start = 0;
        #2; chk("to_hold1", state_o, 2'd1); adv();
        #2; chk("to_hold2", state_o, 2'd1); adv();
        runs = 0;
        for (int i = 0; i < 40; i++) begin
            #2;
            if (state_o != 2'd2) break;
            runs++;
            adv();
        end
        chk("to_run_cycles", runs, TO_N);
        chk("to_state", state_o, 2'd3);
        chk("to_result_to", result_to, 1'b1);
        chk("to_result_valid", result_valid, 1'b0);
        adv();

        // Mailbox store in the same cycle the timeout expires.
        host_start = 1; #2; adv(); host_start = 0;
        #2; adv(); #2; adv();
        #2; chk("both_run", state_o, 2'd2);
        for (int i = 0; i < TO_N - 1; i++) begin #2; adv(); end
        cpu_memwrite = 1; cpu_adr = 8'hFF; cpu_wdata = 8'h5A;
        #2; adv(); idle();
        #2;
        chk("both_state", state_o, 2'd3);
        chk("both_result", {result_valid, result_to, result_data}, {1'b1, 1'b0, 8'h5A});
        adv();

        // Host request during RUN is refused while the core owns the pins; then abort.
        host_start = 1; #2; adv(); host_start = 0;
        #2; adv(); #2; adv();
        #2; chk("ab_run", state_o, 2'd2); adv();
        host_valid = 1; host_write = 1; host_adr = 8'h05; host_wdata = 16'hBEEF;
        cpu_memwrite = 1; cpu_adr = 8'h10; cpu_wdata = 8'h77;
        #2;
        chk("ab_host_ready", host_ready, 1'b0);
        chk("ab_sram_adr", sram_adr, 8'h10);
        chk("ab_sram_we_oe", {sram_we_n, sram_oe_n}, 2'b01);
        chk("ab_sram_wdata", sram_wdata, 16'h0077);
        adv(); idle(); host_abort = 1;
        #2; chk("ab_still_run", state_o, 2'd2); adv(); idle();
        #2;
        chk("ab_state", state_o, 2'd0);
        chk("ab_cpu_reset", cpu_reset, 1'b1);
        chk("ab_result", {result_valid, result_to}, 2'b00);
        adv();
        host_valid = 1; host_adr = 8'h10; #2; adv();
        host_adr = 8'h05; #2; chk("ab_rd10", {host_rvalid, host_rdata}, {1'b1, 16'h0077}); adv(); idle();
        #2; chk("ab_rd05", {host_rvalid, host_rdata}, {1'b1, 16'h0000}); adv();

        // Reset arriving in the cycle of a mailbox store.
        host_start = 1; #2; adv(); host_start = 0;
        for (int i = 0; i < 5; i++) begin #2; adv(); end
        reset = 1; cpu_memwrite = 1; cpu_adr = 8'hFF; cpu_wdata = 8'h33;
        #2; chk("rst_run", state_o, 2'd2); adv();
        reset = 0; idle();
        #2;
        chk("rst_state", state_o, 2'd0);
        chk("rst_result_valid", result_valid, 1'b0);
        chk("rst_cpu_reset", cpu_reset, 1'b1);
        adv();
        host_valid = 1; host_write = 1; host_adr = 8'hFF; host_wdata = 16'h0000;
        #2; adv(); idle();

        for (int i = 0; i < 800; i++) begin
            host_valid   = ($urandom_range(0, 1) == 1);
            host_write   = ($urandom_range(0, 1) == 1);
            host_adr     = ($urandom_range(0, 8) == 8) ? 8'hFF : 8'($urandom_range(0, 7));
            host_wdata   = 16'($urandom);
            host_start   = ($urandom_range(0, 15) == 0);
            host_abort   = ($urandom_range(0, 49) == 0);
            cpu_memwrite = ($urandom_range(0, 9) < 3);
            cpu_adr      = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
            cpu_wdata    = 8'($urandom);
            #2;
            check_model();
            adv();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
